// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the ID-stage decoder/datapath and the hazard controller.
// Latency: none, wires only.
// Backpressure: the slave drives the stall/flush controls back to the master side.
interface pipe_hazard_ctrl_if #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
);
  // ID-stage decode fields
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_reg_write;
  logic             id_jump;
  // Sequencing controls back to the datapath
  logic             id_valid;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pcsrc_q;
  logic [NREG-1:0]  pending;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_reg_write, id_jump,
    input  id_valid, pc_write_en, ifid_write_en, ifid_flush, idex_bubble, pcsrc_q,
    input  pending, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_reg_write, id_jump,
    output id_valid, pc_write_en, ifid_write_en, ifid_flush, idex_bubble, pcsrc_q,
    output pending, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard RAW-hazard stall, jump flush and ID-valid qualification for a 5-stage pipe.
// Latency: controls are combinational from scoreboard state and the ID fields.
// Backpressure: a RAW hazard freezes PC and IfId and bubbles IdEx until the source retires.
module pipe_hazard_ctrl #(
  parameter int NREG   = 32,
  parameter int RF_LAT = 3,
  parameter int CNT_W  = 16
) (
  input logic              i_clk,
  input logic              i_reset,
  pipe_hazard_ctrl_if.slave io_hz
);

  localparam int CW = $clog2(RF_LAT + 1);

  // Per-register cycles remaining until the RF holds the in-flight result.
  logic [CW-1:0]    r_cnt [NREG];
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [NREG-1:0]  w_busy;
  logic [NREG-1:0]  w_load;
  logic             w_valid;
  logic             w_src1_busy;
  logic             w_src2_busy;
  logic             w_hazard;
  logic             w_issue;
  logic             w_flush;

  // Busy mask: a register is busy while its countdown is nonzero.
  always_comb begin
    w_busy = '0;
    for (int r = 0; r < NREG; r++) begin
      w_busy[r] = (r_cnt[r] != '0);
    end
  end

  // Reset gates the valid flag so outputs are quiet before the first reset edge lands.
  assign w_valid     = r_valid & ~i_reset;
  assign w_src1_busy = io_hz.id_use_rs1 & w_busy[io_hz.id_rs1];
  assign w_src2_busy = io_hz.id_use_rs2 & w_busy[io_hz.id_rs2];
  assign w_hazard    = w_valid & (w_src1_busy | w_src2_busy);
  assign w_issue     = w_valid & ~w_hazard;
  assign w_flush     = w_issue & io_hz.id_jump;
  assign w_load      = (w_issue & io_hz.id_reg_write) ? (NREG'(1) << io_hz.id_rd) : '0;

  assign io_hz.id_valid      = w_valid;
  assign io_hz.pc_write_en   = ~w_hazard;
  assign io_hz.ifid_write_en = ~w_hazard;
  assign io_hz.ifid_flush    = w_flush;
  assign io_hz.idex_bubble   = ~w_issue;
  assign io_hz.pcsrc_q       = w_flush;
  assign io_hz.pending       = i_reset ? '0 : w_busy;
  assign io_hz.stall_cnt     = r_stall_cnt;
  assign io_hz.flush_cnt     = r_flush_cnt;

  // Scoreboard: an issuing writer reloads its destination (restarting a WAW), others count down.
  always_ff @(posedge i_clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (i_reset) begin
        r_cnt[r] <= '0;
      end else if (w_load[r]) begin
        r_cnt[r] <= CW'(RF_LAT);
      end else if (w_busy[r]) begin
        r_cnt[r] <= r_cnt[r] - CW'(1);
      end
    end
  end

  // ID valid: squashed by a flush, held across a stall, otherwise a fresh fetch arrives.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
    end else if (w_flush) begin
      r_valid <= 1'b0;
    end else if (!w_hazard) begin
      r_valid <= 1'b1;
    end
  end

  // Saturating performance counters for stall cycles and jump flushes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_hazard && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Scoreboard-based hazard and sequencing controller for the 5-stage pipelined 32-bit datapath (IF, ID, EX, MEM, WB). It tracks in-flight register writes and stalls decode on read-after-write (RAW) dependencies, since the datapath has no forwarding. It also flushes the wrong-path fetch after a taken jump and qualifies the ID-stage instruction as valid or bubble. It sits beside the main decoder, gating PC/IfId writes and squashing IdEx control signals.

Parameters:
- NREG, 32, number of architectural registers tracked.
- RF_LAT, 3, cycles from ID issue until the RF holds the result (EX, MEM, WB register; RF written at the following edge).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  5  source register 1, instruction[26:22].
- id_rs2  in  5  source register 2, instruction[21:17].
- id_rd  in  5  destination register, instruction[31:27].
- id_use_rs1  in  1  decoder: the instruction reads rs1.
- id_use_rs2  in  1  decoder: the instruction reads rs2.
- id_reg_write  in  1  decoder RegWrite for the ID instruction.
- id_jump  in  1  decoder PCSrc, a taken jump in ID.
- id_valid  out  1  the ID instruction is real (not a bubble).
- pc_write_en  out  1  enables the PC update.
- ifid_write_en  out  1  enables the IfId load.
- ifid_flush  out  1  loads a NOP into IfId at the next edge.
- idex_bubble  out  1  forces IdEx RegWrite/MemWrite/MemRead to 0.
- pcsrc_q  out  1  id_jump qualified by issue; drives the PC mux.
- pending  out  NREG  per-register busy mask (counter != 0).
- stall_cnt  out  CNT_W  RAW stall cycles, saturating.
- flush_cnt  out  CNT_W  jump flushes, saturating.

Behaviour:
- State: per-register down-counter cnt[r] (2 bits for RF_LAT=3); valid_q; stall_cnt; flush_cnt.
- Reset (synchronous): all cnt = 0, valid_q = 0, both perf counters = 0.
- Outputs during reset: id_valid=0, pending=0, pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_bubble=1, pcsrc_q=0.
- id_valid = valid_q.
- hazard = id_valid & ((id_use_rs1 & cnt[id_rs1]!=0) | (id_use_rs2 & cnt[id_rs2]!=0)).
- issue = id_valid & ~hazard.
- Stall (hazard=1):
  - pc_write_en=0, ifid_write_en=0, idex_bubble=1, ifid_flush=0, pcsrc_q=0.
  - The scoreboard is not updated by the ID instruction.
  - stall_cnt increments.
- Issue:
  - pc_write_en=1, ifid_write_en=1, idex_bubble=0.
  - If id_reg_write, cnt[id_rd] is loaded with RF_LAT at the edge, overriding its decrement. A WAW reissue restarts the count.
  - If id_jump: pcsrc_q=1, ifid_flush=1, flush_cnt increments.
- Bubble in ID (id_valid=0): idex_bubble=1, pc/ifid enables = 1, no scoreboard update, no flush.
- Every cycle, each nonzero cnt[r] not being loaded decrements by 1.
- RAW timing:
  - Producer issues at edge E. A consumer in ID stalls while cnt != 0 and issues in the cycle after edge E+3, so back-to-back dependents see 3 stall cycles.
  - Exactly one instruction in between gives 2 stalls; two in between gives 1; three or more gives 0.
- valid_q next:
  - 0 if reset.
  - Else 0 if ifid_flush.
  - Else unchanged if stalling.
  - Else 1.
- The first cycle after reset is a bubble.
- Register 0 is tracked like any other register (the RF does not hardwire it).
- A jump in ID with a hazard on its sources stalls first and flushes only when it issues.
- Perf counters saturate at all-ones; no wrap.
- Outputs are combinational from state plus ID inputs; the only state is the registers listed above.

Test Plan:
- Reset 2 cycles, then run → cycle 1 after reset: id_valid=0, idex_bubble=1, pending=0. Cycle 2: id_valid=1.
- ADD r5 then an immediately dependent SUB r6=r5-r1 → pending[5] set for 3 cycles; pc_write_en=0 for exactly 3 cycles; SUB issues in the 4th; stall_cnt=3.
- Writer to r7, one independent instruction, then a reader of r7 → exactly 2 stall cycles. With three intervening instructions → 0 stalls.
- Taken jump in ID with no hazard → ifid_flush=1 and pcsrc_q=1 for 1 cycle; next cycle id_valid=0; flush_cnt=1.
- Two back-to-back writes to r9, then a reader → the counter restarts at the second issue; the reader stalls 3 cycles after the second write.
- Assert reset mid-stall with cnt[5]=2 → next cycle all pending=0, no stall, and counters cleared.
